// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}. Signed operands are converted to
// magnitudes up front, and the signs are applied again after the 32 iterations.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE    = 2'b00,
        S_BY_ZERO = 2'b01,
        S_ON      = 2'b10,
        S_END     = 2'b11
    } state_e;

    // Two's-complement negation, shared by operand magnitude and result sign fix-up
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    state_e      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q,  divisor_d;
    logic        qneg_q,     qneg_d;
    logic        rneg_q,     rneg_d;
    logic [63:0] result_q,   result_d;
    logic        ready_q,    ready_d;

    logic [31:0] abs1_s;
    logic [31:0] abs2_s;
    logic [32:0] diff_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Operand magnitudes, trial subtraction and sign-corrected final values
    always_comb begin
        abs1_s = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
        abs2_s = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
        diff_s = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
        quot_s = qneg_q ? neg32(dividend_q[31:0])  : dividend_q[31:0];
        rem_s  = rneg_q ? neg32(dividend_q[64:33]) : dividend_q[64:33];
    end

    // Next-state and datapath update for the divide sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = 64'h0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = S_BY_ZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = 6'd0;
                        divisor_d  = abs2_s;
                        dividend_d = {32'd0, abs1_s, 1'b0};
                        qneg_d     = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        rneg_d     = signed_div_i & opdata1_i[31];
                    end
                end else begin
                    state_d = S_FREE;
                end
            end
            S_BY_ZERO: begin
                dividend_d = 65'd0;
                state_d    = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                    cnt_d    = 6'd0;
                end else if (cnt_q < 6'd32) begin
                    if (diff_s[32]) begin
                        dividend_d = {dividend_q[63:0], 1'b0};
                    end else begin
                        dividend_d = {diff_s[31:0], dividend_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_s, quot_s};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                    cnt_d    = 6'd0;
                end
            end
            S_END: begin
                // Divide-by-zero arrives here with result already zero; ready rises now.
                if (start_i) begin
                    ready_d = 1'b1;
                end else begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end
            end
            default: begin
                state_d  = S_FREE;
                cnt_d    = 6'd0;
                ready_d  = 1'b0;
                result_d = 64'h0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FREE;
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            result_q   <= 64'h0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results per division.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: truncating division in 64-bit arithmetic, {rem, quot}
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_v, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa   = {{32{a[31]}}, a};
            sb_v = {{32{b[31]}}, b};
        end else begin
            sa   = {32'd0, a};
            sb_v = {32'd0, b};
        end
        q = sa / sb_v;
        r = sa % sb_v;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        sb.push_back(exp);
    endtask

    // lat counts edges from the one that samples start (0) to the one that raises ready
    task automatic wait_ready(input int budget, output int lat, output logic [63:0] res, output bit seen);
        lat  = -1;
        seen = 1'b0;
        res  = 64'h0;
        while (!seen && lat < budget) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready_o === 1'b1) begin
                seen = 1'b1;
                res  = result_o;
            end
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b1;
        opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++;
        if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", ready_o); end
    endtask

    task automatic test_unsigned();
        int lat; logic [63:0] res, exp; bit seen;
        issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        wait_ready(40, lat, res, seen);
        exp = sb.pop_front();
        checks++;
        if (!seen || lat != 33) begin errors++; $display("FAIL udiv_latency got=%0d exp=33 seen=%0b", lat, seen); end
        checks++;
        if (res !== exp) begin errors++; $display("FAIL udiv_result got=%h exp=%h", res, exp); end
        release_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            errors++; $display("FAIL udiv_release got ready=%b result=%h exp 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res, exp; bit seen;
        logic [31:0] a_tab [2] = '{32'hFFFFFFF9, 32'd7};
        logic [31:0] b_tab [2] = '{32'd2, 32'hFFFFFFFE};
        logic [63:0] e_tab [2] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, a_tab[i], b_tab[i], e_tab[i]);
            wait_ready(40, lat, res, seen);
            exp = sb.pop_front();
            checks++;
            if (!seen || lat != 33) begin errors++; $display("FAIL sdiv_latency[%0d] got=%0d exp=33", i, lat); end
            checks++;
            if (res !== exp) begin errors++; $display("FAIL sdiv_result[%0d] got=%h exp=%h", i, res, exp); end
            release_start();
        end
    endtask

    task automatic test_by_zero();
        int lat; logic [63:0] res, exp; bit seen;
        for (int s = 0; s < 2; s++) begin
            issue(s[0], 32'h12345678, 32'd0, 64'h0);
            wait_ready(10, lat, res, seen);
            exp = sb.pop_front();
            checks++;
            if (!seen || lat != 2) begin errors++; $display("FAIL div0_latency[%0d] got=%0d exp=2", s, lat); end
            checks++;
            if (res !== exp) begin errors++; $display("FAIL div0_result[%0d] got=%h exp=%h", s, res, exp); end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (ready_o !== 1'b1 || result_o !== exp) begin
                errors++; $display("FAIL div0_hold[%0d] got ready=%b result=%h", s, ready_o, result_o);
            end
            release_start();
            checks++;
            if (ready_o !== 1'b0) begin errors++; $display("FAIL div0_release[%0d] got=%b exp=0", s, ready_o); end
        end
    endtask

    task automatic test_boundary();
        int lat; logic [63:0] res, exp; bit seen;
        bit          s_tab [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] a_tab [3] = '{32'hFFFFFFFF, 32'h80000000, 32'd5};
        logic [31:0] b_tab [3] = '{32'd1, 32'hFFFFFFFF, 32'd9};
        logic [63:0] e_tab [3] = '{64'h00000000_FFFFFFFF, 64'h00000000_80000000, 64'h00000005_00000000};
        for (int i = 0; i < 3; i++) begin
            issue(s_tab[i], a_tab[i], b_tab[i], e_tab[i]);
            wait_ready(40, lat, res, seen);
            exp = sb.pop_front();
            checks++;
            if (!seen || lat != 33) begin errors++; $display("FAIL bound_latency[%0d] got=%0d exp=33", i, lat); end
            checks++;
            if (res !== exp) begin errors++; $display("FAIL bound_result[%0d] got=%h exp=%h", i, res, exp); end
            release_start();
        end
    endtask

    task automatic test_start_annul();
        int lat; logic [63:0] res, exp; bit seen;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL start_annul_ready got=%b exp=0", ready_o); end
        @(negedge clk);
        annul_i = 1'b0;
        sb.push_back(64'h00000002_0000000E);
        wait_ready(40, lat, res, seen);
        exp = sb.pop_front();
        checks++;
        if (!seen || lat != 33) begin errors++; $display("FAIL start_annul_latency got=%0d exp=33", lat); end
        checks++;
        if (res !== exp) begin errors++; $display("FAIL start_annul_result got=%h exp=%h", res, exp); end
        release_start();
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res, exp; bit seen;
        issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        repeat (11) @(posedge clk);
        #1;
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            errors++; $display("FAIL annul_outputs got ready=%b result=%h exp 0/0", ready_o, result_o);
        end
        void'(sb.pop_back());
        @(negedge clk);
        annul_i = 1'b0;
        sb.push_back(64'h00000002_0000000E);
        wait_ready(40, lat, res, seen);
        exp = sb.pop_front();
        checks++;
        if (!seen || lat != 33) begin errors++; $display("FAIL annul_restart_latency got=%0d exp=33", lat); end
        checks++;
        if (res !== exp) begin errors++; $display("FAIL annul_restart_result got=%h exp=%h", res, exp); end
        release_start();
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] res, exp; bit seen;
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            errors++; $display("FAIL rst_mid_outputs got ready=%b result=%h exp 0/0", ready_o, result_o);
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(64'hFFFFFFFF_FFFFFFFD);
        wait_ready(40, lat, res, seen);
        exp = sb.pop_front();
        checks++;
        if (!seen || lat != 33) begin errors++; $display("FAIL rst_mid_restart_latency got=%0d exp=33", lat); end
        checks++;
        if (res !== exp) begin errors++; $display("FAIL rst_mid_restart_result got=%h exp=%h", res, exp); end
        release_start();
    endtask

    task automatic test_operand_stability();
        int lat; logic [63:0] res, exp; bit seen;
        issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        @(posedge clk);
        @(negedge clk);
        opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd0; signed_div_i = 1'b1;
        wait_ready(40, lat, res, seen);
        exp = sb.pop_front();
        checks++;
        if (!seen || lat != 32) begin errors++; $display("FAIL stable_latency got=%0d exp=32", lat); end
        checks++;
        if (res !== exp) begin errors++; $display("FAIL stable_result got=%h exp=%h", res, exp); end
        release_start();
    endtask

    task automatic test_back_to_back();
        int lat, exp_lat; logic [63:0] res, exp; bit seen;
        bit s; logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (b == 32'd0 && i != 3) b = 32'd3;
            exp_lat = (b == 32'd0) ? 2 : 33;
            issue(s, a, b, model(s, a, b));
            wait_ready(40, lat, res, seen);
            exp = sb.pop_front();
            checks++;
            if (!seen || lat != exp_lat) begin
                errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat);
            end
            checks++;
            if (res !== exp) begin
                errors++; $display("FAIL b2b_result[%0d] s=%0b a=%h b=%h got=%h exp=%h", i, s, a, b, res, exp);
            end
            release_start();
            checks++;
            if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_release[%0d] got=%b exp=0", i, ready_o); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_by_zero();
        test_boundary();
        test_start_annul();
        test_annul();
        test_reset_mid();
        test_operand_stability();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
